// File: rtl/shared_affine_serial.sv
// Nibble-serial affine layer for a Boolean-shared PRINCE state: LANES nibbles of every share per cycle,
// linear part on all shares, constant on share 0 only, forward/inverse selected per accepted state.
module shared_affine_serial #(
  parameter int          SHARES  = 3,
  parameter int          NIBBLES = 16,
  parameter int          LANES   = 4,
  parameter logic [15:0] LIN_F   = 16'h8421,
  parameter logic [3:0]  CST_F   = 4'h0,
  parameter logic [15:0] LIN_I   = 16'h8421,
  parameter logic [3:0]  CST_I   = 4'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_inv,
  input  logic [SHARES*NIBBLES*4-1:0] in_state,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SHARES*NIBBLES*4-1:0] out_state,
  output logic                        busy
);

  localparam int K  = NIBBLES / LANES;
  localparam int W  = SHARES * NIBBLES * 4;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next;
  logic [W-1:0]    data;
  logic [W-1:0]    upd;
  logic [CW-1:0]   cnt;
  logic            inv;
  logic            accept;
  logic            last_group;

  // y[i] = parity of (row i AND x), row i held in m[4i+3:4i]
  function automatic logic [3:0] lin_map(input logic [15:0] m, input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    for (int i = 0; i < 4; i++) begin
      y[i] = ^(m[4*i +: 4] & x);
    end
    return y;
  endfunction

  assign accept     = in_valid & in_ready;
  assign last_group = (cnt == CW'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (accept) next = BUSY; else next = IDLE;
      BUSY: if (last_group) next = DONE; else next = BUSY;
      DONE: begin
        if (out_ready) begin
          if (in_valid) next = BUSY; else next = IDLE;
        end else begin
          next = DONE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
    // Partially processed data is never visible outside DONE
    out_state = out_valid ? data : {W{1'b0}};
  end

  // Each share's nibbles are mapped independently; no share is ever combined with another
  always_comb begin
    upd = data;
    for (int s = 0; s < SHARES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        int idx;
        idx = s * NIBBLES + int'(cnt) * LANES + l;
        upd[idx*4 +: 4] = lin_map(inv ? LIN_I : LIN_F, data[idx*4 +: 4])
                        ^ ((s == 0) ? (inv ? CST_I : CST_F) : 4'h0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= {W{1'b0}};
      cnt  <= {CW{1'b0}};
      inv  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            data <= in_state;
            inv  <= in_inv;
            cnt  <= {CW{1'b0}};
          end
        end
        BUSY: begin
          data <= upd;
          cnt  <= last_group ? {CW{1'b0}} : cnt + 1'b1;
        end
        default: begin
          data <= {W{1'b0}};
          cnt  <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_affine_serial.sv
// Bench for shared_affine_serial: forward map = bit reversal ^ 0xA on share 0, inverse = identity ^ 0x3.
module tb_shared_affine_serial;

  localparam int S = 3;
  localparam int N = 16;
  localparam int L = 4;
  localparam int K = N / L;
  localparam int W = S * N * 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_inv = 1'b0;
  logic [W-1:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_state;
  logic         busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 1;

  logic [W-1:0]  exp_q[$];
  logic [63:0]   unm_q[$];
  int            acc_q[$];

  shared_affine_serial #(
    .SHARES(S), .NIBBLES(N), .LANES(L),
    .LIN_F(16'h1248), .CST_F(4'hA), .LIN_I(16'h8421), .CST_I(4'h3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] map_nib(input logic [3:0] x, input logic iv, input bit with_const);
    logic [3:0] y;
    y = iv ? x : {x[0], x[1], x[2], x[3]};
    if (with_const) y = y ^ (iv ? 4'h3 : 4'hA);
    return y;
  endfunction

  function automatic logic [63:0] xor_shares(input logic [W-1:0] st);
    logic [63:0] u;
    u = 64'h0;
    for (int s = 0; s < S; s++) u = u ^ st[s*64 +: 64];
    return u;
  endfunction

  function automatic logic [W-1:0] model_state(input logic [W-1:0] st, input logic iv);
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < S; s++)
      for (int n = 0; n < N; n++)
        r[(s*N+n)*4 +: 4] = map_nib(st[(s*N+n)*4 +: 4], iv, s == 0);
    return r;
  endfunction

  function automatic logic [63:0] model_unmasked(input logic [W-1:0] st, input logic iv);
    logic [63:0] u;
    logic [63:0] r;
    u = xor_shares(st);
    r = 64'h0;
    for (int n = 0; n < N; n++) r[n*4 +: 4] = map_nib(u[n*4 +: 4], iv, 1'b1);
    return r;
  endfunction

  // consumer readiness, driven from one place
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard bookkeeping on handshakes
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        unm_q.delete();
        acc_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(unm_q.pop_front());
          void'(acc_q.pop_front());
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model_state(in_state, in_inv));
          unm_q.push_back(model_unmasked(in_state, in_inv));
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic ev;
        logic eb;
        ev = (exp_q.size() > 0) && (cyc - acc_q[0] >= K);
        eb = (exp_q.size() > 0) && (cyc - acc_q[0] < K);
        chk("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, ev});
        chk("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, eb});
        chk("in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, (!eb && (!ev || out_ready))});
        if (ev && out_valid) begin
          chk("out_state", out_state, exp_q[0]);
          chk("unmasked", {{(W-64){1'b0}}, xor_shares(out_state)}, {{(W-64){1'b0}}, unm_q[0]});
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] st, input logic iv);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    in_state = st;
    in_inv   = iv;
    in_valid = 1'b1;
    while (!got && n < 60) begin
      @(posedge clk);
      got = in_ready;
      n++;
    end
    #1;
    in_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
    end
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid 0 expected 1 within 40 cycles", name);
    end else begin
      chk(name, out_state, exp);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_state();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [W-1:0] va;
    logic [W-1:0] vb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("rst_busy", {{(W-1){1'b0}}, busy}, '0);
    chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    chk("rst_out_state", out_state, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send('0, 1'b0);
    expect_result("zero_fwd", {128'h0, 64'hAAAA_AAAA_AAAA_AAAA});
    send('0, 1'b1);
    expect_result("zero_inv", {128'h0, 64'h3333_3333_3333_3333});
    send({128'h0, 64'h0123_4567_89AB_CDEF}, 1'b0);
    expect_result("seq_share0", {128'h0, 64'hA2E6_80C4_B3F7_91D5});
    send({64'h0, 64'h0123_4567_89AB_CDEF, 64'h0}, 1'b0);
    expect_result("seq_share1", {64'h0, 64'h084C_2A6E_195D_3B7F, 64'hAAAA_AAAA_AAAA_AAAA});

    // in_inv toggling while busy must not change the result
    send({64'h0, 64'h0, 64'hFEDC_BA98_7654_3210}, 1'b1);
    in_inv = 1'b0;
    @(posedge clk);
    #1;
    in_inv = 1'b1;
    expect_result("inv_toggle", {64'h0, 64'h0, 64'hCDEF_89AB_4567_0123});

    // long stall in DONE with a pending new state, then same-edge handoff
    ready_mode = 0;
    @(posedge clk);
    #1;
    va = rand_state();
    vb = rand_state();
    send(va, 1'b0);
    in_state = vb;
    in_inv   = 1'b1;
    in_valid = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("stall_state", out_state, model_state(va, 1'b0));
    ready_mode = 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_result("handoff", model_state(vb, 1'b1));

    // reset on the second BUSY cycle discards the state
    send(rand_state(), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    chk("midrst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    ready_mode = 2;
    for (int i = 0; i < 1000; i++) send(rand_state(), 1'($urandom_range(0, 1)));

    ready_mode = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("drain", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
